stream_prefetcher: RTL

STREAM_PREFETCHER -- requirements
Module: stream_prefetcher

---
 rtl/stream_prefetcher.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/stream_prefetcher.sv
// Next-line stream prefetcher between an upstream line requester and memory.
// Keeps a circular buffer of consecutive lines ahead of the last demand address.
module stream_prefetcher #(
  parameter int ENTRIES    = 4,
  parameter int LINE_BYTES = 32,
  parameter int ADDR_W     = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    pf_en,
  input  logic                    up_read,
  input  logic [ADDR_W-1:0]       up_addr,
  output logic                    up_resp,
  output logic [8*LINE_BYTES-1:0] up_rdata,
  output logic                    dfp_read,
  output logic [ADDR_W-1:0]       dfp_addr,
  output logic                    dfp_write,
  output logic [8*LINE_BYTES-1:0] dfp_wdata,
  input  logic [8*LINE_BYTES-1:0] dfp_rdata,
  input  logic                    dfp_resp
);

  localparam int LW  = 8 * LINE_BYTES;
  localparam int PW  = $clog2(ENTRIES);
  localparam int CW  = PW + 1;
  localparam int OFF = $clog2(LINE_BYTES);

  localparam logic [ADDR_W-1:0] LINE  = ADDR_W'(LINE_BYTES);
  localparam logic [ADDR_W-1:0] AMASK = ~(LINE - 1'b1);
  localparam logic [CW-1:0]     FULL  = CW'(ENTRIES);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_PF     = 3'd1;
  localparam logic [2:0] S_DEMAND = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_HIT    = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [PW-1:0]     head_q, head_d;
  logic [CW-1:0]     count_q, count_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] pf_addr_q, pf_addr_d;
  logic              sv_q, sv_d;
  logic [LW-1:0]     buf_q [ENTRIES];

  logic              wr_en;
  logic [PW-1:0]     wr_idx;
  logic [ADDR_W-1:0] req_line;
  logic [ADDR_W-1:0] next_pf;
  logic              sv;
  logic              hit;
  logic              pf_take;
  logic              full;

  assign req_line = up_addr & AMASK;
  assign next_pf  = base_q + (ADDR_W'(count_q) << OFF);
  // Dropping pf_en invalidates the stream in the same cycle.
  assign sv       = sv_q & pf_en;
  assign full     = (count_q == FULL);
  assign hit      = up_read & sv & (count_q != '0) & (req_line == base_q);
  assign pf_take  = up_read & sv & (count_q == '0) & (req_line == pf_addr_q);
  assign wr_idx   = head_q + count_q[PW-1:0];

  assign dfp_write = 1'b0;
  assign dfp_wdata = '0;

  always_comb begin
    state_d   = state_q;
    head_d    = head_q;
    count_d   = count_q;
    base_d    = base_q;
    pf_addr_d = pf_addr_q;
    sv_d      = sv;
    wr_en     = 1'b0;
    up_resp   = 1'b0;
    up_rdata  = dfp_rdata;
    dfp_read  = 1'b0;
    dfp_addr  = pf_addr_q;
    unique case (state_q)
      S_IDLE: begin
        if (up_read) begin
          state_d = hit ? S_HIT : S_DEMAND;
        end else if (sv && !full) begin
          state_d   = S_PF;
          pf_addr_d = next_pf;
        end
      end
      S_HIT: begin
        up_resp  = 1'b1;
        up_rdata = buf_q[head_q];
        head_d   = head_q + 1'b1;
        count_d  = count_q - 1'b1;
        base_d   = base_q + LINE;
        state_d  = S_IDLE;
      end
      S_PF: begin
        dfp_read = 1'b1;
        if (dfp_resp) begin
          state_d = S_IDLE;
          if (pf_take) begin
            up_resp = 1'b1;
            base_d  = base_q + LINE;
          end else if (sv) begin
            wr_en   = 1'b1;
            count_d = count_q + 1'b1;
          end
        end else if (up_read && !pf_take) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        dfp_read = 1'b1;
        if (dfp_resp) begin
          if (!up_read)  state_d = S_IDLE;
          else if (hit)  state_d = S_HIT;
          else           state_d = S_DEMAND;
        end
      end
      S_DEMAND: begin
        dfp_read = 1'b1;
        dfp_addr = req_line;
        if (dfp_resp) begin
          up_resp = 1'b1;
          count_d = '0;
          base_d  = req_line + LINE;
          sv_d    = pf_en;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      head_q    <= '0;
      count_q   <= '0;
      base_q    <= '0;
      pf_addr_q <= '0;
      sv_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      head_q    <= head_d;
      count_q   <= count_d;
      base_q    <= base_d;
      pf_addr_q <= pf_addr_d;
      sv_q      <= sv_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) buf_q[wr_idx] <= dfp_rdata;
  end

endmodule
